uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side buffer directly downstream of uart_receiver. Captures each
//   rx_ready strobe (rx_data + rx_error) into a DEPTH-entry FIFO and presents
//   bytes to the host/consumer through a first-word-fall-through valid/ready
//   port. Tracks overflow and framing-error statistics so the consumer can
//   drain at its own pace without losing status information.
// PARAMETERS
//   DATA_BITS  8   width of rx_data / out_data
//   DEPTH      16  number of entries; power of 2, >= 2
//   DROP_ERR   0   1: frames with rx_error=1 are discarded, not stored
// PORTS
//   clk        in   1            system clock (same clock as uart_receiver)
//   rst_n      in   1            asynchronous reset, active low
//   rx_ready   in   1            one-clk strobe from uart_receiver: frame done
//   rx_data    in   DATA_BITS    received byte, valid when rx_ready=1
//   rx_error   in   1            framing error for this frame, valid with rx_ready
//   out_valid  out  1            head entry available (FIFO not empty)
//   out_data   out  DATA_BITS    head byte; 0 when out_valid=0
//   out_err    out  1            head entry framing-error flag; 0 when out_valid=0
//   out_ready  in   1            consumer accepts head when out_valid=1
//   level      out  $clog2(DEPTH+1)  current entry count, 0..DEPTH
//   full       out  1            level == DEPTH
//   overflow   out  1            sticky: a frame was lost because FIFO was full
//   ovf_clr    in   1            one-clk pulse, clears overflow
//   err_count  out  8            saturating count of frames with rx_error=1
// BEHAVIOUR
//   Reset (rst_n=0, async): wr/rd pointers=0, level=0, out_valid=0,
//     out_data=0, out_err=0, full=0, overflow=0, err_count=0. Storage not reset.
//   Push: rx_ready=1 and entry accepted -> {rx_err,rx_data} written at wr_ptr,
//     wr_ptr+1 (wraps mod DEPTH). Pop: out_valid & out_ready -> rd_ptr+1 (wraps).
//   Accept rule: push accepted if !full, or full and a pop occurs same cycle.
//   Full & rx_ready & no pop: frame discarded, overflow<=1 next cycle.
//   DROP_ERR=1 & rx_error=1: frame never stored (no overflow, no level change).
//   err_count increments on every rx_ready with rx_error=1 (stored, dropped
//     or lost to overflow); saturates at 255; cleared only by reset.
//   Latency: push in cycle N -> out_valid=1 (if previously empty) in N+1;
//     no same-cycle bypass from rx_* to out_*.
//   FWFT: out_data/out_err show head entry combinationally from rd_ptr while
//     out_valid=1; holds stable until popped.
//   level: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
//   Empty + rx_ready: push; pop impossible that cycle (out_valid=0).
//   ovf_clr and new overflow same cycle: overflow stays 1 (set wins).
//   out_ready while out_valid=0: ignored, pointers unchanged.
//   Reset mid-stream: all entries discarded immediately; a frame whose
//     rx_ready coincides with reset assertion is lost.
// TESTING
//   1 rx_ready x3 with 0x55,0xFF,0x00 (err=0), out_ready=1 -> out_data 0x55,0xFF,
//     0x00 in order, out_err=0, level returns to 0.
//   2 out_ready=0, push 16 bytes 0x00..0x0F -> full=1, level=16; 17th push 0xAA
//     -> overflow=1, level=16; drain -> 0x00..0x0F, 0xAA never appears.
//   3 full, push 0x33 with simultaneous pop -> pop gives 0x00, level stays 16,
//     0x33 is last entry read; overflow stays 0.
//   4 DROP_ERR=0: push 0xA5 err=1 -> out_data=0xA5,out_err=1, err_count=1;
//     DROP_ERR=1 same stimulus -> out_valid stays 0, err_count=1.
//   5 overflow=1, ovf_clr pulse -> overflow=0 next cycle; ovf_clr coincident
//     with new overflow -> overflow remains 1.
//   6 level=5, assert rst_n=0 mid-stream -> out_valid/level/overflow/err_count
//     0 immediately; after release push 0xCC -> first read 0xCC.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Generic FWFT FIFO: head visible combinationally, write-to-read latency 1 clk.
// Backpressure: wr_rdy low when full unless a read frees a slot in the same cycle.
module fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_vld,
   input  logic [WIDTH-1:0]             wr_dat,
   output logic                         wr_rdy,
   output logic                         rd_vld,
   output logic [WIDTH-1:0]             rd_dat,
   input  logic                         rd_rdy,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (cnt == LW'(DEPTH));
   assign rd_vld  = (cnt != '0);
   assign wr_rdy  = !full || rd_rdy;
   assign wr_fire = wr_vld && wr_rdy;
   assign rd_fire = rd_vld && rd_rdy;
   assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
   assign level   = cnt;

   // Storage is deliberately left out of reset; rd_vld gates what is visible.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
         if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_fire, rd_fire})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// UART receive buffer: stores {rx_error, rx_data} per rx_ready strobe, FWFT output 1 clk after push.
// Backpressure: none toward the receiver; frames arriving while full are dropped and flagged in overflow.
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16,
   parameter bit DROP_ERR  = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx_ready,
   input  logic [DATA_BITS-1:0]         rx_data,
   input  logic                         rx_error,
   output logic                         out_valid,
   output logic [DATA_BITS-1:0]         out_data,
   output logic                         out_err,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         overflow,
   input  logic                         ovf_clr,
   output logic [7:0]                   err_count
);
   logic               push_vld;
   logic               push_rdy;
   logic               ovf_set;
   logic [DATA_BITS:0] head;

   assign push_vld = rx_ready && !(DROP_ERR && rx_error);
   assign ovf_set  = push_vld && !push_rdy;

   fifo #(
      .WIDTH (DATA_BITS + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (push_vld),
      .wr_dat ({rx_error, rx_data}),
      .wr_rdy (push_rdy),
      .rd_vld (out_valid),
      .rd_dat (head),
      .rd_rdy (out_ready),
      .level  (level),
      .full   (full)
   );

   assign {out_err, out_data} = head;

   // A frame lost in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         err_count <= 8'd0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (rx_ready && rx_error && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, two instances (keep / drop error frames)
// checked every cycle against queue-based reference models.
module tb_uart_rx_fifo;
   localparam int DB    = 8;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx_ready, rx_error, out_ready, ovf_clr, rdy_d;
   logic [DB-1:0] rx_data;

   logic          out_valid, out_err, full, overflow;
   logic [DB-1:0] out_data;
   logic [LW-1:0] level;
   logic [7:0]    err_count;

   logic          out_valid_d, out_err_d, full_d, overflow_d;
   logic [DB-1:0] out_data_d;
   logic [LW-1:0] level_d;
   logic [7:0]    err_count_d;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   bit         ov0, ov1;
   int         ec0, ec1;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .DROP_ERR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data), .rx_error(rx_error),
      .out_valid(out_valid), .out_data(out_data), .out_err(out_err), .out_ready(out_ready),
      .level(level), .full(full), .overflow(overflow), .ovf_clr(ovf_clr), .err_count(err_count)
   );

   uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .DROP_ERR(1'b1)) dut_d (
      .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data), .rx_error(rx_error),
      .out_valid(out_valid_d), .out_data(out_data_d), .out_err(out_err_d), .out_ready(rdy_d),
      .level(level_d), .full(full_d), .overflow(overflow_d), .ovf_clr(ovf_clr), .err_count(err_count_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rr, input logic [7:0] d, input logic e,
                        input logic ordy, input logic clr);
      rx_ready  = rr;
      rx_data   = d;
      rx_error  = e;
      out_ready = ordy;
      ovf_clr   = clr;
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      ov0 = 0; ov1 = 0;
      ec0 = 0; ec1 = 0;
   endtask

   // Advance the reference models by one clock using the inputs now applied, then clock the DUTs.
   task automatic step();
      bit lost0, lost1;
      lost0 = 0;
      lost1 = 0;
      if (rst_n) begin
         if (q0.size() > 0 && out_ready) q0.delete(0);
         if (q1.size() > 0 && rdy_d)     q1.delete(0);
         if (rx_ready) begin
            if (rx_error && ec0 < 255) ec0++;
            if (rx_error && ec1 < 255) ec1++;
            if (q0.size() < DEPTH) q0.push_back({rx_error, rx_data});
            else lost0 = 1;
            if (!rx_error) begin
               if (q1.size() < DEPTH) q1.push_back({rx_error, rx_data});
               else lost1 = 1;
            end
         end
         ov0 = lost0 ? 1'b1 : (ovf_clr ? 1'b0 : ov0);
         ov1 = lost1 ? 1'b1 : (ovf_clr ? 1'b0 : ov1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [8:0] h0, h1;
      h0 = (q0.size() > 0) ? q0[0] : 9'd0;
      h1 = (q1.size() > 0) ? q1[0] : 9'd0;
      chk({tag, ".vld"},  32'(out_valid), 32'(q0.size() > 0));
      chk({tag, ".dat"},  32'(out_data),  32'(h0[7:0]));
      chk({tag, ".err"},  32'(out_err),   32'(h0[8]));
      chk({tag, ".lvl"},  32'(level),     32'(q0.size()));
      chk({tag, ".full"}, 32'(full),      32'(q0.size() == DEPTH));
      chk({tag, ".ovf"},  32'(overflow),  32'(ov0));
      chk({tag, ".ecnt"}, 32'(err_count), 32'(ec0));
      chk({tag, ".d_vld"},  32'(out_valid_d), 32'(q1.size() > 0));
      chk({tag, ".d_dat"},  32'(out_data_d),  32'(h1[7:0]));
      chk({tag, ".d_err"},  32'(out_err_d),   32'(h1[8]));
      chk({tag, ".d_lvl"},  32'(level_d),     32'(q1.size()));
      chk({tag, ".d_full"}, 32'(full_d),      32'(q1.size() == DEPTH));
      chk({tag, ".d_ovf"},  32'(overflow_d),  32'(ov1));
      chk({tag, ".d_ecnt"}, 32'(err_count_d), 32'(ec1));
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rdy_d = 1'b1;
      drive(0, 8'h00, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("post_reset");

      // T1: three frames streamed straight through
      drive(1, 8'h55, 0, 1, 0); step(); chk("t1.d0", 32'(out_data), 32'h55); check_all("t1a");
      drive(1, 8'hFF, 0, 1, 0); step(); chk("t1.d1", 32'(out_data), 32'hFF); check_all("t1b");
      drive(1, 8'h00, 0, 1, 0); step(); chk("t1.d2", 32'(out_data), 32'h00); check_all("t1c");
      drive(0, 8'h00, 0, 1, 0); step(); chk("t1.lvl", 32'(level), 32'd0); check_all("t1d");

      // T2: fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 8'(i), 0, 0, 0); step(); check_all("t2.fill");
      end
      chk("t2.full", 32'(full), 32'd1);
      chk("t2.lvl16", 32'(level), 32'd16);
      drive(1, 8'hAA, 0, 0, 0); step();
      chk("t2.ovf", 32'(overflow), 32'd1);
      chk("t2.lvl_ovf", 32'(level), 32'd16);
      check_all("t2.ovf");
      drive(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t2.drain", 32'(out_data), 32'(i));
         step();
      end
      chk("t2.empty", 32'(out_valid), 32'd0);
      check_all("t2.end");

      // T5a: clear pulse drops the sticky flag
      drive(0, 8'h00, 0, 0, 1); step();
      chk("t5.clr", 32'(overflow), 32'd0);
      check_all("t5.clr");

      // T3: push while full with simultaneous pop
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 8'(i), 0, 0, 0); step();
      end
      drive(1, 8'h33, 0, 1, 0);
      chk("t3.head", 32'(out_data), 32'h00);
      step();
      chk("t3.lvl", 32'(level), 32'd16);
      chk("t3.ovf", 32'(overflow), 32'd0);
      check_all("t3.swap");
      drive(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t3.drain", 32'(out_data), (i == DEPTH - 1) ? 32'h33 : 32'(i + 1));
         step();
      end
      check_all("t3.end");

      // T4: error frame kept by one instance, dropped by the other
      pulse_reset();
      drive(1, 8'hA5, 1, 0, 0); step();
      chk("t4.dat", 32'(out_data), 32'hA5);
      chk("t4.err", 32'(out_err), 32'd1);
      chk("t4.ecnt", 32'(err_count), 32'd1);
      chk("t4.d_vld", 32'(out_valid_d), 32'd0);
      chk("t4.d_ecnt", 32'(err_count_d), 32'd1);
      check_all("t4");
      drive(0, 8'h00, 0, 1, 0); step(); check_all("t4.drain");

      // T5b: clear coincident with a new loss keeps overflow set
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 8'(8'h40 + i), 0, 0, 0); step();
      end
      drive(1, 8'hEE, 0, 0, 0); step();
      chk("t5.set", 32'(overflow), 32'd1);
      drive(1, 8'hEF, 0, 0, 1); step();
      chk("t5.setwins", 32'(overflow), 32'd1);
      check_all("t5");

      // T6: asynchronous reset mid-stream at level 5
      drive(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < DEPTH - 5; i++) step();
      chk("t6.lvl5", 32'(level), 32'd5);
      check_all("t6.pre");
      drive(1, 8'h77, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6.vld0", 32'(out_valid), 32'd0);
      chk("t6.lvl0", 32'(level), 32'd0);
      chk("t6.ovf0", 32'(overflow), 32'd0);
      chk("t6.ecnt0", 32'(err_count), 32'd0);
      step();
      check_all("t6.inrst");
      rst_n = 1'b1;
      drive(1, 8'hCC, 0, 0, 0); step();
      chk("t6.first", 32'(out_data), 32'hCC);
      check_all("t6.post");
      drive(0, 8'h00, 0, 1, 0); step(); check_all("t6.drain");

      // Random traffic against the models
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         rdy_d = ($urandom_range(0, 1) == 1);
         step();
         check_all("rand");
      end

      // Error-counter saturation
      for (int i = 0; i < 270; i++) begin
         drive(1, 8'($urandom), 1, ($urandom_range(0, 1) == 1), 0);
         step();
      end
      chk("sat.ecnt", 32'(err_count), 32'd255);
      chk("sat.d_ecnt", 32'(err_count_d), 32'd255);
      check_all("sat");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
